sim_scan_ctrl: RTL and testbench
================================

Name: sim_scan_ctrl

Overview:
- Parametrised run/halt/dump controller for the poco_r core; takes over the reset, run-length and state-dump sequencing that is currently hard-coded in the bench.
- Sequence: drives the core's reset for a programmable number of cycles, lets the core run for a cycle budget, then freezes it.
- After the freeze, it scans REG_N register-file entries and MEM_N data-memory words through read ports and streams each value out over a valid/ready channel.
- Sits beside poco_r in the harness; the core's clock is shared.

Parameters:
- DATA_W, 16, width of register and memory words
- REG_N, 8, register entries scanned (must be >= 1)
- REG_AW, 3, register read-address width (2^REG_AW >= REG_N)
- MEM_N, 8, memory words scanned, from address MEM_BASE (must be >= 1)
- MEM_BASE, 0, first memory address scanned
- ADDR_W, 16, memory read-address width
- RST_CYC, 3, cycles core_rst_n is held low (must be >= 1)
- RUN_CYC, 50, cycles the core runs before halt (must be >= 1)
- CNT_W, 32, width of cycle_cnt

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a sequence; sampled only in IDLE or DONE
- core_rst_n  out  1  active-low reset to the core
- core_hold  out  1  stall/freeze request to the core
- reg_raddr  out  REG_AW  register-file read address; combinational read
- reg_rdata  in  DATA_W  register-file read data
- mem_raddr  out  ADDR_W  data-memory read address; combinational read
- mem_rdata  in  DATA_W  data-memory read data
- out_valid  out  1  dump word valid
- out_ready  in  1  consumer accepts the word
- out_src  out  1  source of the word: 0 = register, 1 = memory
- out_idx  out  16  entry index within its source (0-based)
- out_data  out  DATA_W  dumped value
- busy  out  1  high from RESET through SCAN_MEM
- done  out  1  high in DONE
- cycle_cnt  out  CNT_W  count of cycles spent in RUN

Behaviour:
- Reset applies on any clock edge with rst=1, regardless of state. It forces:
  - state = IDLE
  - core_rst_n = 0, core_hold = 0
  - out_valid = 0, out_src = 0, out_idx = 0, out_data = 0
  - busy = 0, done = 0, cycle_cnt = 0
  - reg_raddr = 0, mem_raddr = MEM_BASE
- Reset mid-sequence discards any pending output word; no partial dump resumes.
- All outputs are registered.
- IDLE: core_rst_n = 0. On start = 1, go to RESET next cycle; cycle_cnt is cleared at that point.
- RESET: core_rst_n = 0 for exactly RST_CYC cycles, then go to RUN.
- RUN: core_rst_n = 1, core_hold = 0.
  - cycle_cnt increments each RUN cycle.
  - After RUN_CYC cycles, go to HALT; cycle_cnt = RUN_CYC on exit.
- HALT: core_hold = 1 for one cycle; core_rst_n stays 1. Then go to SCAN_REG.
  - core_hold stays 1 through DONE.
  - core_hold drops to 0 only on a restart or on reset.
- SCAN_REG: reg_raddr = index i, starting at 0.
  - The output register loads reg_rdata when !out_valid or (out_valid & out_ready), setting out_valid = 1, out_src = 0, out_idx = i. Then i increments.
  - The first word is valid one cycle after entering SCAN_REG.
  - Once entry REG_N-1 is loaded, go to SCAN_MEM; i resets to 0.
- SCAN_MEM: same rules, with mem_raddr = MEM_BASE + i, out_src = 1, out_idx = i.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - Once entry MEM_N-1 is loaded, go to DRAIN.
- Handshake:
  - A word transfers when out_valid & out_ready on a clock edge.
  - While out_valid & !out_ready, out_data, out_src and out_idx hold stable and the scan index does not advance.
  - Full throughput with out_ready held at 1: one word per cycle.
  - out_valid never drops without a transfer.
- DRAIN (part of SCAN_MEM for busy purposes): wait for the last word to transfer, then out_valid = 0 and go to DONE.
- DONE: done = 1, busy = 0; cycle_cnt is held. start = 1 restarts at RESET (core_hold = 0, done = 0).
- start in RESET/RUN/HALT/SCAN states is ignored.
- Total words per sequence: REG_N + MEM_N, in fixed order: registers 0..REG_N-1, then memory 0..MEM_N-1.

Test Plan:
- Reset and start, defaults, out_ready = 1:
  - start pulse at cycle 0 -> core_rst_n low for cycles 1-3, high from cycle 4.
  - core_hold high at cycle 54 (HALT); cycle_cnt = 50.
  - 16 words follow on consecutive cycles from cycle 56; done at cycle 72.
- Dump ordering, register file preset to regs[i] = 0x1000+i and mem[i] = 0x2000+i:
  - out_src/out_idx/out_data run (0,0,0x1000) … (0,7,0x1007), then (1,0,0x2000) … (1,7,0x2007).
- Backpressure: out_ready low for 5 cycles while word (0,3) is presented -> word (0,3) held constant with out_valid = 1 throughout; no word lost or duplicated; 16 words total.
- Alternating out_ready = 1,0 -> 16 transfers in 31–32 cycles; order unchanged.
- Reset mid-scan: rst asserted during SCAN_MEM at i = 2 -> next cycle IDLE, out_valid = 0, core_rst_n = 0, core_hold = 0, done = 0; a new start produces a full 16-word dump from (0,0).
- Restart and ignored start:
  - start pulses during RUN leave the sequence unchanged (cycle_cnt still ends at 50).
  - start in DONE re-runs the sequence and clears cycle_cnt at RESET entry.

Source files
------------

// File: rtl/sim_scan_ctrl.sv
// Run/halt/dump sequencer for the poco_r harness: resets the core, runs it for a
// fixed cycle budget, freezes it, then streams register and memory contents out.
module sim_scan_ctrl #(
  parameter int DATA_W   = 16,
  parameter int REG_N    = 8,
  parameter int REG_AW   = 3,
  parameter int MEM_N    = 8,
  parameter int MEM_BASE = 0,
  parameter int ADDR_W   = 16,
  parameter int RST_CYC  = 3,
  parameter int RUN_CYC  = 50,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              core_rst_n,
  output logic              core_hold,
  output logic [REG_AW-1:0] reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_src,
  output logic [15:0]       out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RESET    = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_HALT     = 3'd3;
  localparam logic [2:0] S_SCAN_REG = 3'd4;
  localparam logic [2:0] S_SCAN_MEM = 3'd5;
  localparam logic [2:0] S_DRAIN    = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [ADDR_W-1:0] MEM_BASE_A = ADDR_W'(MEM_BASE);
  localparam logic [15:0]       REG_LAST   = 16'(REG_N - 1);
  localparam logic [15:0]       MEM_LAST   = 16'(MEM_N - 1);

  logic [2:0]  state;
  logic [31:0] phase_cnt;
  logic [15:0] idx;
  logic        load;

  // Output slot is free when empty or being drained this edge.
  assign load = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      phase_cnt  <= '0;
      idx        <= '0;
      core_rst_n <= 1'b0;
      core_hold  <= 1'b0;
      reg_raddr  <= '0;
      mem_raddr  <= MEM_BASE_A;
      out_valid  <= 1'b0;
      out_src    <= 1'b0;
      out_idx    <= '0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cycle_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RESET;
            phase_cnt  <= '0;
            cycle_cnt  <= '0;
            core_rst_n <= 1'b0;
            core_hold  <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        S_RESET: begin
          if (phase_cnt == 32'(RST_CYC - 1)) begin
            state      <= S_RUN;
            phase_cnt  <= '0;
            core_rst_n <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        S_RUN: begin
          cycle_cnt <= cycle_cnt + CNT_W'(1);
          if (phase_cnt == 32'(RUN_CYC - 1)) begin
            state     <= S_HALT;
            core_hold <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 32'd1;
          end
        end
        S_HALT: begin
          state <= S_SCAN_REG;
          idx   <= '0;
        end
        S_SCAN_REG: begin
          if (load) begin
            out_valid <= 1'b1;
            out_src   <= 1'b0;
            out_idx   <= idx;
            out_data  <= reg_rdata;
            if (idx == REG_LAST) begin
              state     <= S_SCAN_MEM;
              idx       <= '0;
              reg_raddr <= '0;
            end else begin
              idx       <= idx + 16'd1;
              reg_raddr <= REG_AW'(idx + 16'd1);
            end
          end
        end
        S_SCAN_MEM: begin
          if (load) begin
            out_valid <= 1'b1;
            out_src   <= 1'b1;
            out_idx   <= idx;
            out_data  <= mem_rdata;
            if (idx == MEM_LAST) begin
              state     <= S_DRAIN;
              idx       <= '0;
              mem_raddr <= MEM_BASE_A;
            end else begin
              idx       <= idx + 16'd1;
              // Wraps modulo 2^ADDR_W by truncation.
              mem_raddr <= MEM_BASE_A + ADDR_W'(idx) + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_scan_ctrl.sv
// Directed bench for sim_scan_ctrl at default parameters: timing of the
// reset/run/halt sequence, dump order, backpressure, mid-scan reset and restart.
module tb_sim_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic        core_rst_n, core_hold, out_valid, out_src, busy, done;
  logic [2:0]  reg_raddr;
  logic [15:0] reg_rdata, mem_raddr, mem_rdata, out_idx, out_data;
  logic [31:0] cycle_cnt;
  int          total = 0;
  int          bad = 0;
  int          ncyc;
  int          k;

  always #5 clk = ~clk;

  // Preset contents: regs[i] = 0x1000+i, mem[i] = 0x2000+i; out-of-range reads flag 0xdead.
  assign reg_rdata = 16'h1000 + {13'd0, reg_raddr};
  assign mem_rdata = (mem_raddr < 16'd8) ? (16'h2000 + mem_raddr) : 16'hdead;

  sim_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .core_rst_n(core_rst_n), .core_hold(core_hold),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .out_idx(out_idx), .out_data(out_data),
    .busy(busy), .done(done), .cycle_cnt(cycle_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Leaves the bench at cycle 1 (first RESET cycle).
  task automatic begin_seq();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Advance from cycle 'from' to cycle 56 (first valid word), optionally pulsing start in RUN.
  task automatic run_to_scan(input int from, input bit poke);
    for (int c = from; c <= 55; c++) begin
      start = poke && (c >= 10) && (c <= 12);
      tick();
      if (c + 1 == 53) chk("run_hold", 64'(core_hold), 64'd0);
      if (c + 1 == 54) begin
        chk("halt_hold", 64'(core_hold), 64'd1);
        chk("halt_cnt", 64'(cycle_cnt), 64'd50);
        chk("halt_rstn", 64'(core_rst_n), 64'd1);
      end
    end
    start = 1'b0;
    chk("first_valid", 64'(out_valid), 64'd1);
  endtask

  // mode 0: ready always; 1: stall 5 cycles on word (0,3); 2: alternate 1,0
  task automatic collect(input int mode, output int cyc);
    int          n = 0;
    int          stall = 0;
    bit          tog = 1'b1;
    logic [15:0] eidx;
    logic [15:0] edata;
    cyc = 0;
    while (n < 16 && cyc < 200) begin
      case (mode)
        1: begin
          if (out_valid && !out_src && out_idx == 16'd3 && stall < 5) begin
            out_ready = 1'b0;
            stall++;
            chk("bp_data", 64'(out_data), 64'h1003);
          end else begin
            out_ready = 1'b1;
          end
        end
        2: begin
          out_ready = tog;
          tog = !tog;
        end
        default: out_ready = 1'b1;
      endcase
      if (out_valid && out_ready) begin
        eidx  = 16'(n % 8);
        edata = ((n >= 8) ? 16'h2000 : 16'h1000) + eidx;
        chk("word", 64'({out_src, out_idx, out_data}), 64'({(n >= 8), eidx, edata}));
        n++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    chk("word_count", 64'(n), 64'd16);
    if (mode == 1) chk("bp_stalls", 64'(stall), 64'd5);
    chk("done_after", 64'(done), 64'd1);
    chk("valid_after", 64'(out_valid), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("rst_hold", 64'(core_hold), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'({out_src, out_idx, out_data}), 64'd0);
    chk("rst_busy_done", 64'({busy, done}), 64'd0);
    chk("rst_cnt", 64'(cycle_cnt), 64'd0);
    chk("rst_addr", 64'({reg_raddr, mem_raddr}), 64'd0);

    // Sequence 1: timing with defaults
    begin_seq();
    for (int c = 1; c <= 3; c++) begin
      chk("reset_rstn", 64'(core_rst_n), 64'd0);
      chk("reset_busy", 64'(busy), 64'd1);
      tick();
    end
    chk("run_rstn", 64'(core_rst_n), 64'd1);
    chk("run_hold0", 64'(core_hold), 64'd0);
    run_to_scan(4, 1'b0);
    collect(0, ncyc);
    chk("seq1_cycles", 64'(ncyc), 64'd16);
    chk("done_cnt", 64'(cycle_cnt), 64'd50);
    chk("done_hold", 64'(core_hold), 64'd1);

    // Sequence 2: restart from DONE, ignored starts in RUN, backpressure on (0,3)
    begin_seq();
    chk("restart_cnt", 64'(cycle_cnt), 64'd0);
    chk("restart_flags", 64'({core_hold, done, core_rst_n}), 64'd0);
    run_to_scan(1, 1'b1);
    collect(1, ncyc);
    chk("bp_cycles", 64'(ncyc), 64'd21);

    // Sequence 3: alternating ready
    begin_seq();
    run_to_scan(1, 1'b0);
    collect(2, ncyc);
    chk("alt_cycles", 64'(ncyc >= 31 && ncyc <= 32), 64'd1);

    // Sequence 4: reset while memory word 2 is presented, then a clean rerun
    begin_seq();
    run_to_scan(1, 1'b0);
    out_ready = 1'b1;
    k = 0;
    while (!(out_valid && out_src && out_idx == 16'd2) && k < 40) begin
      tick();
      k++;
    end
    chk("reach_mem2", 64'(k < 40), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst", 64'({out_valid, core_rst_n, core_hold, done, busy}), 64'd0);
    begin_seq();
    run_to_scan(1, 1'b0);
    collect(0, ncyc);
    chk("rerun_cycles", 64'(ncyc), 64'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
